// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the Wishbone bus arbiter: bus widths, timeout
// read data, grant FSM state type and the grant-index width helper.
package wb_arbiter_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam logic [31:0] WB_TIMEOUT_DATA = 32'hFFFF_FFFF;
  localparam int WB_TO_CNT_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Width of a master index; a single-master build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: returns the first requester found after
// i_last_idx, searching upwards and wrapping around.
module wb_arb_rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_idx,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  // w_cand[k] is the master at distance k+1 from the previous owner.
  logic [IW-1:0] w_cand [N];

  for (genvar k = 0; k < N; k++) begin : g_cand
    assign w_cand[k] = IW'((int'(i_last_idx) + k + 1) % N);
  end

  // Scan from the farthest candidate down so the nearest requester wins.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      o_idx = i_req[w_cand[k]] ? w_cand[k] : o_idx;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the system bus between NUM_MASTERS
// masters. A grant lasts for the owner's whole cyc; handover to a waiting
// master happens at the release edge without an idle cycle.
// Optional feature: define WB_ARB_TIMEOUT_EN to build the stalled-strobe
// timeout (TIMEOUT_CYCLES) that force-terminates a cycle with error data.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  output logic [WB_DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  output logic                            s_we_o,
  output logic                            s_stb_o,
  output logic                            s_cyc_o,
  input  logic [WB_DAT_W-1:0]             s_dat_i,
  input  logic                            s_ack_i,
  output logic [NUM_MASTERS-1:0]          gnt_o,
  output logic                            timeout_o
);

  localparam int IW = idx_width(NUM_MASTERS);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

  arb_state_e             r_state;
  logic [IW-1:0]          r_gnt_idx;
  logic [IW-1:0]          r_last_idx;
  logic [NUM_MASTERS-1:0] r_gnt_oh;

  logic          w_pick_any;
  logic [IW-1:0] w_pick_idx;
  logic          w_owned;
  logic          w_own_cyc;
  logic          w_own_stb;
  logic          w_rearb;
  logic          w_timeout;

  // Per-master views of the packed request buses.
  logic [WB_ADR_W-1:0] w_adr [NUM_MASTERS];
  logic [WB_DAT_W-1:0] w_dat [NUM_MASTERS];
  logic [WB_SEL_W-1:0] w_sel [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign w_adr[i] = m_adr_i[i*WB_ADR_W +: WB_ADR_W];
    assign w_dat[i] = m_dat_i[i*WB_DAT_W +: WB_DAT_W];
    assign w_sel[i] = m_sel_i[i*WB_SEL_W +: WB_SEL_W];
  end

  wb_arb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .i_req      (m_cyc_i),
    .i_last_idx (r_last_idx),
    .o_any      (w_pick_any),
    .o_idx      (w_pick_idx)
  );

  assign w_owned   = (r_state == ST_OWNED);
  assign w_own_cyc = m_cyc_i[r_gnt_idx];
  assign w_own_stb = m_stb_i[r_gnt_idx];
  // Arbitrate whenever the bus is free or the owner has let go of cyc.
  assign w_rearb   = !w_owned || !w_own_cyc;
  assign gnt_o     = r_gnt_oh;

  // Grant FSM: hold while the owner keeps cyc, otherwise re-pick at this edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_gnt_idx  <= '0;
      r_last_idx <= LAST_RST;
      r_gnt_oh   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_OWNED: begin
          if (w_rearb) begin
            if (w_pick_any) begin
              r_state    <= ST_OWNED;
              r_gnt_idx  <= w_pick_idx;
              r_last_idx <= w_pick_idx;
              r_gnt_oh   <= NUM_MASTERS'(1) << w_pick_idx;
            end else begin
              r_state  <= ST_IDLE;
              r_gnt_oh <= '0;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_gnt_oh <= '0;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [WB_TO_CNT_W-1:0] TO_LAST = WB_TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WB_TO_CNT_W-1:0] r_to_cnt;
  logic                   w_stall;

  // A stalled beat is an owner strobe the slave has not acked yet.
  assign w_stall   = w_owned & w_own_cyc & w_own_stb & ~s_ack_i;
  // The cycle holding the last allowed count is the forced-termination cycle.
  assign w_timeout = w_stall & (r_to_cnt == TO_LAST);

  // Stall counter: restarts on ack, on termination and whenever the grant can move.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_to_cnt <= '0;
    end else if (w_rearb || s_ack_i || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_stall) begin
      r_to_cnt <= r_to_cnt + WB_TO_CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Output muxes: route the owner to the slave bus and steer the ack back.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m_ack_o   = '0;
    timeout_o = w_timeout;
    if (w_owned) begin
      s_adr_o            = w_adr[r_gnt_idx];
      s_dat_o            = w_dat[r_gnt_idx];
      s_sel_o            = w_sel[r_gnt_idx];
      s_we_o             = m_we_i[r_gnt_idx];
      s_stb_o            = w_own_stb & ~w_timeout;
      s_cyc_o            = w_own_cyc & ~w_timeout;
      m_ack_o[r_gnt_idx] = (s_ack_i & w_own_cyc) | w_timeout;
    end else begin
      m_ack_o = '0;
    end
  end

  // Read data is broadcast; forced to the error pattern on a timeout and
  // held at zero while reset is asserted.
  always_comb begin
    m_dat_o = s_dat_i;
    if (wb_rst_i) begin
      m_dat_o = '0;
    end else if (w_timeout) begin
      m_dat_o = WB_TIMEOUT_DATA;
    end else begin
      m_dat_o = s_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (two masters, TIMEOUT_CYCLES=16). Expected
// values are queued when stimulus is applied and compared when the DUT
// output is sampled.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [63:0] m_adr;
  logic [63:0] m_dat;
  logic [7:0]  m_sel;
  logic [1:0]  m_we;
  logic [1:0]  m_stb;
  logic [1:0]  m_cyc;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic        s_stb_o;
  logic        s_cyc_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  logic [63:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_sel_i   (m_sel),
    .m_we_i    (m_we),
    .m_stb_i   (m_stb),
    .m_cyc_i   (m_cyc),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_stb_o   (s_stb_o),
    .s_cyc_o   (s_cyc_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .gnt_o     (gnt_o),
    .timeout_o (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp_push(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    m_adr   = {32'hB000_0020, 32'hA000_0010};
    m_dat   = {32'h2222_2222, 32'h1111_1111};
    m_sel   = 8'h3F;
    m_we    = 2'b01;
    m_stb   = 2'b00;
    m_cyc   = 2'b00;
    s_dat_i = 32'h1234_5678;
    s_ack_i = 1'b0;

    // Reset state: every output low, even read data
    exp_push(64'h0); exp_push(64'h0); exp_push(64'h0); exp_push(64'h0); exp_push(64'h0);
    #1;
    check("rst_gnt", 64'(gnt_o));
    check("rst_s_cyc", 64'(s_cyc_o));
    check("rst_m_ack", 64'(m_ack_o));
    check("rst_timeout", 64'(timeout_o));
    check("rst_m_dat", 64'(m_dat_o));
    tick; tick;
    rst = 1'b0;

    // 1: lone master 0, one-cycle arbitration latency
    m_cyc = 2'b01; m_stb = 2'b01;
    exp_push(64'h0);
    settle;
    check("t1_latency_gnt", 64'(gnt_o));
    exp_push(64'h1); exp_push(64'h1); exp_push(64'hA000_0010); exp_push(64'hF); exp_push(64'h1);
    tick;
    check("t1_gnt", 64'(gnt_o));
    check("t1_s_cyc", 64'(s_cyc_o));
    check("t1_s_adr", 64'(s_adr_o));
    check("t1_s_sel", 64'(s_sel_o));
    check("t1_s_we", 64'(s_we_o));
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    exp_push(64'h1); exp_push(64'hDEAD_BEEF); exp_push(64'h1111_1111);
    settle;
    check("t1_m_ack", 64'(m_ack_o));
    check("t1_m_dat", 64'(m_dat_o));
    check("t1_s_dat", 64'(s_dat_o));
    tick;
    s_ack_i = 1'b0; m_cyc = 2'b00; m_stb = 2'b00;
    exp_push(64'h0);
    settle;
    check("t1_cyc_drop", 64'(s_cyc_o));
    exp_push(64'h0);
    tick;
    check("t1_idle", 64'(gnt_o));

    // Lone master 1 moves the round-robin pointer to 1
    m_cyc = 2'b10; m_stb = 2'b10;
    exp_push(64'h2); exp_push(64'hB000_0020); exp_push(64'h0);
    tick;
    check("m1_gnt", 64'(gnt_o));
    check("m1_s_adr", 64'(s_adr_o));
    check("m1_s_we", 64'(s_we_o));
    m_cyc = 2'b00; m_stb = 2'b00;
    tick;

    // 2: both request from idle, master 0 first, back-to-back handover
    m_cyc = 2'b11; m_stb = 2'b11;
    exp_push(64'h1);
    tick;
    check("t2_gnt0", 64'(gnt_o));
    m_cyc = 2'b10;
    exp_push(64'h2); exp_push(64'h1);
    tick;
    check("t2_handover", 64'(gnt_o));
    check("t2_no_gap", 64'(s_cyc_o));
    m_cyc = 2'b01;
    exp_push(64'h1);
    tick;
    check("t2_repeat", 64'(gnt_o));
    m_cyc = 2'b00;
    tick;
    m_cyc = 2'b11;
    exp_push(64'h2);
    tick;
    check("t2_rr_from_idle", 64'(gnt_o));
    m_cyc = 2'b00;
    tick;

    // 3: master 0 keeps the bus over three beats while master 1 waits
    m_cyc = 2'b11; m_stb = 2'b11;
    tick;
    for (int b = 0; b < 3; b++) begin
      s_ack_i = 1'b1;
      exp_push(64'h1); exp_push(64'h1);
      settle;
      check("t3_beat_ack", 64'(m_ack_o));
      check("t3_beat_gnt", 64'(gnt_o));
      tick;
      s_ack_i = 1'b0;
      exp_push(64'h0);
      settle;
      check("t3_gap_ack", 64'(m_ack_o));
      tick;
    end
    m_cyc = 2'b10;
    exp_push(64'h2);
    tick;
    check("t3_release", 64'(gnt_o));

    // 4: ack in the owner's last cycle, one ack only, then handover
    m_cyc = 2'b11; s_ack_i = 1'b1;
    exp_push(64'h2);
    settle;
    check("t4_ack", 64'(m_ack_o));
    tick;
    m_cyc = 2'b01;
    exp_push(64'h0);
    settle;
    check("t4_no_second_ack", 64'(m_ack_o));
    s_ack_i = 1'b0;
    exp_push(64'h1);
    tick;
    check("t4_handover", 64'(gnt_o));

    // 5: asynchronous reset while master 1 owns the bus
    m_cyc = 2'b10;
    tick;
    s_ack_i = 1'b1;
    exp_push(64'h2); exp_push(64'h2);
    settle;
    check("t5_pre_gnt", 64'(gnt_o));
    check("t5_pre_ack", 64'(m_ack_o));
    rst = 1'b1;
    exp_push(64'h0); exp_push(64'h0); exp_push(64'h0);
    #1;
    check("t5_rst_gnt", 64'(gnt_o));
    check("t5_rst_s_cyc", 64'(s_cyc_o));
    check("t5_rst_m_ack", 64'(m_ack_o));
    tick;
    rst = 1'b0; s_ack_i = 1'b0; m_cyc = 2'b11; m_stb = 2'b11;
    exp_push(64'h1);
    tick;
    check("t5_first_after_rst", 64'(gnt_o));
    m_cyc = 2'b00; m_stb = 2'b00;
    tick;

    // 6: stalled slave
    m_cyc = 2'b01; m_stb = 2'b01; s_dat_i = 32'h0000_5A5A;
    tick;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 17; c++) begin
      exp_push(64'(c == 16));
      exp_push((c == 16) ? 64'h1 : 64'h0);
      exp_push((c == 16) ? 64'h0 : 64'h1);
      exp_push((c == 16) ? 64'hFFFF_FFFF : 64'h5A5A);
      settle;
      check("t6_timeout", 64'(timeout_o));
      check("t6_m_ack", 64'(m_ack_o));
      check("t6_s_stb", 64'(s_stb_o));
      check("t6_m_dat", 64'(m_dat_o));
      tick;
    end
`else
    for (int c = 1; c <= 20; c++) begin
      exp_push(64'h0); exp_push(64'h0); exp_push(64'h1);
      settle;
      check("t6_timeout_off", 64'(timeout_o));
      check("t6_m_ack_off", 64'(m_ack_o));
      check("t6_s_stb_off", 64'(s_stb_o));
      tick;
    end
`endif
    m_cyc = 2'b00; m_stb = 2'b00;
    exp_push(64'h0);
    tick;
    check("end_idle", 64'(gnt_o));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
